// File: rtl/demux_sipo_pkg.sv
// demux_sipo_pkg: shared constants, the select-width derivation and the
// output-buffer state type for the 1:8 demultiplexing deserializer.
// Optional build macro used by this design: DEMUX_SIPO_MSB_FIRST_EN
// (first serial bit lands in the word MSB instead of the LSB).
package demux_sipo_pkg;

  // Default word width; must be a power of two and at least 2.
  localparam int WIDTH_DEF = 8;

  // Width of the select/index counter for a given word width.
  function automatic int selWidth(input int width);
    return $clog2(width);
  endfunction

  localparam int SEL_W_DEF = selWidth(WIDTH_DEF);

  // Output buffer: EMPTY holds nothing to transfer, FULL holds one word.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bufState_e;

endpackage : demux_sipo_pkg

// File: rtl/demux_sipo_ctr.sv
// demux_sipo_ctr: modulo-WIDTH index counter with increment, frame restart
// and a wrap flag. Also used as the select counter of the matching
// serializer, so it knows nothing about data.
module demux_sipo_ctr
  import demux_sipo_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int SEL_W = selWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             sync,
  output logic [SEL_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  logic [SEL_W-1:0] r_cnt;
  logic [SEL_W-1:0] w_cntNext;
  logic             w_atLast;

  // Next index: a restart wins over everything, and a restart that coincides
  // with an increment already counts that increment as index 0 being used.
  always_comb begin
    w_atLast  = (r_cnt == LAST);
    w_cntNext = r_cnt;
    if (sync) begin
      w_cntNext = inc ? ONE : '0;
    end else if (inc) begin
      w_cntNext = w_atLast ? '0 : r_cnt + ONE;
    end
  end

  // Index register; reset puts the next bit at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cntNext;
    end
  end

  // A wrap only counts when the terminal index is actually consumed and the
  // frame is not being restarted on the same edge.
  always_comb begin
    wrap = inc && w_atLast && !sync;
  end

  assign cnt = r_cnt;

endmodule : demux_sipo_ctr

// File: rtl/demux_sipo.sv
// demux_sipo: 1:8 demultiplexing deserializer. Serial bits are steered by
// the index counter into an assembly register; each completed word is handed
// to a single-entry valid/ready output buffer with a sticky overflow flag.
// Build option DEMUX_SIPO_MSB_FIRST_EN: index i fills word bit WIDTH-1-i.
module demux_sipo
  import demux_sipo_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int SEL_W = selWidth(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

`ifdef DEMUX_SIPO_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] POS0 = LAST;
`else
  localparam logic [SEL_W-1:0] POS0 = '0;
`endif

  logic [SEL_W-1:0] w_sel;
  logic             w_complete;
  logic [SEL_W-1:0] w_pos;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] w_asmWritten;
  logic [WIDTH-1:0] w_asmNext;
  bufState_e        r_state;
  bufState_e        w_stateNext;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] r_outWord;
  logic             r_ovf;

  demux_sipo_ctr #(
    .WIDTH (WIDTH)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_valid),
    .sync  (sync),
    .cnt   (w_sel),
    .wrap  (w_complete)
  );

  // Map the steering index to a word bit position (mirrored in MSB-first builds).
  always_comb begin
`ifdef DEMUX_SIPO_MSB_FIRST_EN
    w_pos = LAST - w_sel;
`else
    w_pos = w_sel;
`endif
  end

  // The word as it looks with the current bit written; on completion this is
  // the full word, so the final bit needs no extra cycle.
  always_comb begin
    w_asmWritten        = r_asm;
    w_asmWritten[w_pos] = in_bit;
  end

  // Next assembly contents: restart clears (keeping a coincident bit at
  // index 0), completion clears, otherwise an accepted bit is merged in.
  always_comb begin
    w_asmNext = r_asm;
    if (sync) begin
      w_asmNext = '0;
      if (in_valid) begin
        w_asmNext[POS0] = in_bit;
      end
    end else if (in_valid) begin
      w_asmNext = w_complete ? '0 : w_asmWritten;
    end
  end

  // Assembly register; a partial frame is discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
    end else begin
      r_asm <= w_asmNext;
    end
  end

  // Output buffer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Output buffer next state: a completion always leaves it FULL (either
  // freshly loaded or holding the old word), a bare transfer empties it.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      EMPTY: begin
        if (w_complete) begin
          w_stateNext = FULL;
        end
      end
      FULL: begin
        if (out_ready && !w_complete) begin
          w_stateNext = EMPTY;
        end
      end
      default: begin
        w_stateNext = EMPTY;
      end
    endcase
  end

  // Output buffer decodes: valid flag, when to load a new word, when to drop one.
  always_comb begin
    out_valid = (r_state == FULL);
    w_load    = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      EMPTY: begin
        w_load = w_complete;
      end
      FULL: begin
        w_load = w_complete && out_ready;
        w_drop = w_complete && !out_ready;
      end
      default: begin
        w_load = 1'b0;
        w_drop = 1'b0;
      end
    endcase
  end

  // Output word holds its value unless a new word is accepted into the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outWord <= '0;
    end else if (w_load) begin
      r_outWord <= w_asmWritten;
    end
  end

  // Sticky overflow: a drop sets it and beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign sel      = w_sel;
  assign out_word = r_outWord;
  assign overflow = r_ovf;

endmodule : demux_sipo

// File: tb/tb_demux_sipo.sv
// tb_demux_sipo: directed and randomized checks of demux_sipo against a
// frame-level reference model (bit list, one-word buffer, sticky flag).
module tb_demux_sipo;

  localparam int W  = 8;
  localparam int SW = 3;

`ifdef DEMUX_SIPO_MSB_FIRST_EN
  localparam logic [W-1:0] EXP_FIRST = 8'h6D;
  localparam bit           MSB_FIRST = 1'b1;
`else
  localparam logic [W-1:0] EXP_FIRST = 8'hB6;
  localparam bit           MSB_FIRST = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_bit;
  logic          in_valid;
  logic          sync;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_word;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic          clr_ovf;

  int total = 0;
  int bad   = 0;

  // Reference model state: bits received so far in this frame and the buffer.
  int           mCount;
  bit           mBits [W];
  bit           mValid;
  logic [W-1:0] mWord;
  bit           mOvf;

  demux_sipo #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .sync      (sync),
    .sel       (sel),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] packFrame();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (MSB_FIRST) w[W-1-i] = mBits[i];
      else           w[i]     = mBits[i];
    end
    return w;
  endfunction

  task automatic modelReset();
    mCount = 0;
    for (int i = 0; i < W; i++) mBits[i] = 1'b0;
    mValid = 1'b0;
    mWord  = '0;
    mOvf   = 1'b0;
  endtask

  // One clock edge of the frame-level model using the currently driven inputs.
  task automatic modelEdge();
    bit           done;
    bit           xfer;
    logic [W-1:0] word;
    done = 1'b0;
    word = '0;
    xfer = mValid && out_ready;
    if (sync) begin
      for (int i = 0; i < W; i++) mBits[i] = 1'b0;
      mCount = 0;
      if (in_valid) begin
        mBits[0] = in_bit;
        mCount   = 1;
      end
    end else if (in_valid) begin
      mBits[mCount] = in_bit;
      mCount++;
      if (mCount == W) begin
        done = 1'b1;
        word = packFrame();
        for (int i = 0; i < W; i++) mBits[i] = 1'b0;
        mCount = 0;
      end
    end
    if (done && mValid && !out_ready) begin
      mOvf = 1'b1;
    end else begin
      if (clr_ovf) mOvf = 1'b0;
      if (done) begin
        mWord  = word;
        mValid = 1'b1;
      end else if (xfer) begin
        mValid = 1'b0;
      end
    end
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput(input string tag);
    checkEq({tag, ".sel"},       32'(sel),       32'(mCount));
    checkEq({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
    checkEq({tag, ".out_word"},  32'(out_word),  32'(mWord));
    checkEq({tag, ".overflow"},  32'(overflow),  32'(mOvf));
  endtask

  // Drive one cycle of inputs from a falling edge, step the model at the
  // rising edge, check just after it, then return to the next falling edge.
  task automatic applyStimulus(input string tag, input bit iv, input bit ib,
                               input bit sy, input bit rdy, input bit clr);
    in_valid  = iv;
    in_bit    = ib;
    sync      = sy;
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  // Send a whole frame so that the produced word equals value in this build.
  task automatic sendWord(input string tag, input logic [W-1:0] value,
                          input bit rdy, input bit rdyLast);
    bit b;
    for (int i = 0; i < W; i++) begin
      b = MSB_FIRST ? value[W-1-i] : value[i];
      applyStimulus(tag, 1'b1, b, 1'b0, (i == W-1) ? rdyLast : rdy, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] seq;
    rst_n     = 1'b0;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    sync      = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;

    // Basic frame, continuous bits, consumer always ready.
    seq = 8'b1011_0110;
    for (int i = 0; i < W; i++) begin
      applyStimulus("basic", 1'b1, seq[i], 1'b0, 1'b1, 1'b0);
      checkEq("basic.selStep", 32'(sel), 32'((i + 1) % W));
    end
    checkEq("basic.valid", 32'(out_valid), 32'd1);
    checkEq("basic.word", 32'(out_word), 32'(EXP_FIRST));
    applyStimulus("basic.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkEq("basic.validDrop", 32'(out_valid), 32'd0);

    // Same frame with a three-cycle gap after the fourth bit.
    for (int i = 0; i < W; i++) begin
      applyStimulus("gap", 1'b1, seq[i], 1'b0, 1'b1, 1'b0);
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus("gap.idle", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
          checkEq("gap.selHold", 32'(sel), 32'd4);
        end
      end
    end
    checkEq("gap.word", 32'(out_word), 32'(EXP_FIRST));
    applyStimulus("gap.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Consumer stalled: second word is dropped and overflow sticks until cleared.
    sendWord("ovf.w1", 8'hB6, 1'b0, 1'b0);
    sendWord("ovf.w2", 8'h5A, 1'b0, 1'b0);
    checkEq("ovf.wordKept", 32'(out_word), 32'hB6);
    checkEq("ovf.set", 32'(overflow), 32'd1);
    applyStimulus("ovf.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEq("ovf.sticky", 32'(overflow), 32'd1);
    applyStimulus("ovf.clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkEq("ovf.cleared", 32'(overflow), 32'd0);

    // Buffer FULL, transfer on the same edge as the next completion.
    sendWord("xfer", 8'hC3, 1'b0, 1'b1);
    checkEq("xfer.valid", 32'(out_valid), 32'd1);
    checkEq("xfer.word", 32'(out_word), 32'hC3);
    checkEq("xfer.noOvf", 32'(overflow), 32'd0);
    applyStimulus("xfer.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart mid-frame with a coincident bit, then complete with ones.
    for (int i = 0; i < 5; i++) applyStimulus("sync.pre", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("sync.hit", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkEq("sync.sel", 32'(sel), 32'd1);
    checkEq("sync.noValid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus("sync.post", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkEq("sync.word", 32'(out_word), 32'hFF);
    checkEq("sync.valid", 32'(out_valid), 32'd1);

    // Asynchronous reset mid-frame at index 3.
    for (int i = 0; i < 3; i++) applyStimulus("arst.pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkEq("arst.selPre", 32'(sel), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.during");
    checkEq("arst.wordZero", 32'(out_word), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sendWord("arst.frame", 8'h3C, 1'b1, 1'b1);
    checkEq("arst.word", 32'(out_word), 32'h3C);
    applyStimulus("arst.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand",
                    ($urandom_range(3, 0) != 0),
                    1'($urandom_range(1, 0)),
                    ($urandom_range(31, 0) == 0),
                    1'($urandom_range(1, 0)),
                    ($urandom_range(15, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux_sipo
